// File: rtl/tape_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tape_unit_pkg
//  Purpose  : Shared constants and types for the tape unit: symbol width,
//             blank symbol, head-move direction encoding and FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package tape_unit_pkg;

    localparam int          SYM_W     = 3;
    localparam logic [2:0]  SYM_BLANK = 3'b000;

    localparam logic        DIR_LEFT  = 1'b0;
    localparam logic        DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } tape_state_e;

endpackage : tape_unit_pkg
`default_nettype wire

// File: rtl/tape_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : tape_unit_if
//  Purpose  : Bundles the tape unit control, load, step and status signals.
//  Ports    : master modport drives clr/load/start/step and the step payload
//             (write_sym, direction); slave modport (the tape unit) returns
//             step_ready, the symbol under the head (s2..s0), head_pos,
//             load_ovf, fault and state_o.
//  Revision : 1.0  initial release
// ============================================================================
interface tape_unit_if
    import tape_unit_pkg::*;
#(
    parameter int TAPE_LEN = 16
) ();
    localparam int ADDR_W = $clog2(TAPE_LEN);

    logic               clr;
    logic               load_valid;
    logic [SYM_W-1:0]   load_sym;
    logic               start;
    logic               step_valid;
    logic               step_ready;
    logic [SYM_W-1:0]   write_sym;
    logic               direction;
    logic               s2;
    logic               s1;
    logic               s0;
    logic [ADDR_W-1:0]  head_pos;
    logic               load_ovf;
    logic               fault;
    logic [1:0]         state_o;

    modport master (
        output clr, load_valid, load_sym, start, step_valid, write_sym, direction,
        input  step_ready, s2, s1, s0, head_pos, load_ovf, fault, state_o
    );

    modport slave (
        input  clr, load_valid, load_sym, start, step_valid, write_sym, direction,
        output step_ready, s2, s1, s0, head_pos, load_ovf, fault, state_o
    );

endinterface : tape_unit_if
`default_nettype wire

// File: rtl/tape_unit_head_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : tape_unit_head_ctr
//  Purpose  : Up/down head position counter with enable, direction and
//             synchronous clear. Reports an edge hit when the requested move
//             would leave the tape.
//  Ports    : clk, rst_n (async active-low), clr_i (sync clear to 0),
//             en_i (apply one move), dir_i (0 left / 1 right),
//             pos_o (current head index), edge_hit_o (move would fall off).
//  Config   : TAPE_UNIT_WRAP_EN defined -> circular tape, edge_hit_o is 0.
//  Revision : 1.0  initial release
// ============================================================================
module tape_unit_head_ctr
    import tape_unit_pkg::*;
#(
    parameter  int TAPE_LEN = 16,
    localparam int ADDR_W   = $clog2(TAPE_LEN)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr_i,
    input  wire logic              en_i,
    input  wire logic              dir_i,
    output      logic [ADDR_W-1:0] pos_o,
    output      logic              edge_hit_o
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] pos_q;
    logic [ADDR_W-1:0] pos_d;
    logic [ADDR_W-1:0] w_next;
    logic              w_at_lo;
    logic              w_at_hi;
    logic              w_edge;

    assign w_at_lo = (pos_q == '0);
    assign w_at_hi = (pos_q == C_LAST);

    always_comb begin
        w_next = pos_q;
        w_edge = 1'b0;
`ifdef TAPE_UNIT_WRAP_EN
        // Explicit wrap keeps non-power-of-two tape lengths circular too.
        if (dir_i == DIR_RIGHT) begin
            w_next = w_at_hi ? '0 : pos_q + C_ONE;
        end else begin
            w_next = w_at_lo ? C_LAST : pos_q - C_ONE;
        end
`else
        // Falling off either edge holds the head in place.
        w_edge = (dir_i == DIR_LEFT) ? w_at_lo : w_at_hi;
        if (!w_edge) begin
            w_next = (dir_i == DIR_RIGHT) ? pos_q + C_ONE : pos_q - C_ONE;
        end
`endif
    end

    always_comb begin
        pos_d = pos_q;
        if (clr_i) begin
            pos_d = '0;
        end else if (en_i) begin
            pos_d = w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o      = pos_q;
    assign edge_hit_o = w_edge;

endmodule : tape_unit_head_ctr
`default_nettype wire

// File: rtl/tape_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tape_unit
//  Purpose  : Symbol tape and read/write head of the machine. Loads the
//             initial tape in IDLE, performs one write-and-move step per
//             cycle in RUN and presents the symbol under the head.
//  Ports    : clk, rst_n (async active-low), bus (tape_unit_if.slave):
//             clr, load_valid/load_sym, start, step_valid/step_ready,
//             write_sym, direction, s2..s0, head_pos, load_ovf, fault,
//             state_o.
//  Config   : TAPE_UNIT_WRAP_EN defined -> circular tape, fault never set.
//  Revision : 1.0  initial release
// ============================================================================
module tape_unit
    import tape_unit_pkg::*;
#(
    parameter int TAPE_LEN = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    tape_unit_if.slave  bus
);

    localparam int                ADDR_W = $clog2(TAPE_LEN);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN   = 2'(ST_RUN);
    localparam logic [1:0] S_FAULT = 2'(ST_FAULT);

    logic [1:0]         state_q,    state_d;
    logic [ADDR_W-1:0]  load_ptr_q, load_ptr_d;
    // Set once the last cell has been loaded; the pointer alone cannot tell
    // "about to write the last cell" from "last cell already written".
    logic               load_full_q, load_full_d;
    logic               load_ovf_q, load_ovf_d;
    logic               fault_q,    fault_d;
    logic [SYM_W-1:0]   tape_q [TAPE_LEN];

    logic [ADDR_W-1:0]  w_head;
    logic               w_edge_hit;
    logic               w_idle;
    logic               w_load;
    logic               w_load_ovf;
    logic               w_step;
    logic [SYM_W-1:0]   w_sym;

    assign w_idle     = (state_q == S_IDLE);
    assign w_load     = w_idle && !bus.clr && bus.load_valid && !load_full_q;
    assign w_load_ovf = w_idle && !bus.clr && bus.load_valid &&  load_full_q;
    assign w_step     = (state_q == S_RUN) && !bus.clr && bus.step_valid;

    tape_unit_head_ctr #(
        .TAPE_LEN   (TAPE_LEN)
    ) u_head_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.clr || (w_idle && bus.start)),
        .en_i       (w_step),
        .dir_i      (bus.direction),
        .pos_o      (w_head),
        .edge_hit_o (w_edge_hit)
    );

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        load_full_d = load_full_q;
        load_ovf_d  = load_ovf_q;
        fault_d     = fault_q;
        if (bus.clr) begin
            state_d     = S_IDLE;
            load_ptr_d  = '0;
            load_full_d = 1'b0;
            load_ovf_d  = 1'b0;
            fault_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_load) begin
                        if (load_ptr_q == C_LAST) begin
                            load_full_d = 1'b1;
                        end else begin
                            load_ptr_d = load_ptr_q + C_ONE;
                        end
                    end
                    if (w_load_ovf) begin
                        load_ovf_d = 1'b1;
                    end
                    // A simultaneous load has already used the old pointer.
                    if (bus.start) begin
                        state_d     = S_RUN;
                        load_ptr_d  = '0;
                        load_full_d = 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_step && w_edge_hit) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            load_ptr_q  <= '0;
            load_full_q <= 1'b0;
            load_ovf_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            load_full_q <= load_full_d;
            load_ovf_q  <= load_ovf_d;
            fault_q     <= fault_d;
        end
    end

    // Load and step are exclusive by state, so at most one write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                tape_q[i] <= SYM_BLANK;
            end
        end else begin
            if (w_load) begin
                tape_q[load_ptr_q] <= bus.load_sym;
            end
            if (w_step) begin
                tape_q[w_head] <= bus.write_sym;
            end
        end
    end

    assign w_sym = tape_q[w_head];

    assign bus.s2         = w_sym[2];
    assign bus.s1         = w_sym[1];
    assign bus.s0         = w_sym[0];
    assign bus.head_pos   = w_head;
    assign bus.step_ready = (state_q == S_RUN);
    assign bus.load_ovf   = load_ovf_q;
    assign bus.fault      = fault_q;
    assign bus.state_o    = state_q;

endmodule : tape_unit
`default_nettype wire

// File: tb/tb_tape_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tape_unit
//  Purpose  : Self-checking bench for tape_unit. Stimulus pushes expected
//             status snapshots into a queue; a negedge monitor pops and
//             compares them against the DUT outputs and tape contents.
//  Config   : expectations follow TAPE_UNIT_WRAP_EN when it is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tape_unit;
    import tape_unit_pkg::*;

    localparam int TL = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tape_unit_if #(.TAPE_LEN(TL)) bus ();

    tape_unit #(.TAPE_LEN(TL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]      st;
        logic [3:0]      head;
        logic [2:0]      sym;
        logic            rdy;
        logic            flt;
        logic            ovf;
        bit              chk_tape;
        logic [TL*3-1:0] tape;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [2:0]  etape [TL];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.clr        = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_sym   = 3'b000;
        bus.start      = 1'b0;
        bus.step_valid = 1'b0;
        bus.write_sym  = 3'b000;
        bus.direction  = 1'b0;
    endtask

    task automatic expect_st(input string nm, input logic [1:0] st, input logic [3:0] hd,
                             input logic [2:0] sy, input logic rdy, input logic flt,
                             input logic ovf, input bit ct);
        exp_t e;
        e.st = st; e.head = hd; e.sym = sy; e.rdy = rdy; e.flt = flt; e.ovf = ovf;
        e.chk_tape = ct;
        for (int i = 0; i < TL; i++) e.tape[i*3 +: 3] = etape[i];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every pending expectation at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t            e;
            string           nm;
            logic [TL*3-1:0] at;
            bit              bad;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            for (int i = 0; i < TL; i++) at[i*3 +: 3] = dut.tape_q[i];
            vectors++;
            bad = (bus.state_o !== e.st) || (bus.head_pos !== e.head) ||
                  ({bus.s2, bus.s1, bus.s0} !== e.sym) || (bus.step_ready !== e.rdy) ||
                  (bus.fault !== e.flt) || (bus.load_ovf !== e.ovf) ||
                  (e.chk_tape && (at !== e.tape));
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got st=%0d head=%0d sym=%b rdy=%b flt=%b ovf=%b tape=%h | want st=%0d head=%0d sym=%b rdy=%b flt=%b ovf=%b tape=%h",
                         nm, bus.state_o, bus.head_pos, {bus.s2, bus.s1, bus.s0}, bus.step_ready,
                         bus.fault, bus.load_ovf, at, e.st, e.head, e.sym, e.rdy, e.flt, e.ovf,
                         e.chk_tape ? e.tape : at);
            end
        end
    end

    initial begin
        logic [2:0] syms [3];
        logic [2:0] s;
        syms[0] = 3'b001; syms[1] = 3'b010; syms[2] = 3'b100;
        idle_in();
        for (int i = 0; i < TL; i++) etape[i] = 3'b000;

        // Reset state
        cyc();
        expect_st("reset", 2'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Load three cells, then start
        for (int k = 0; k < 3; k++) begin
            bus.load_valid = 1'b1;
            bus.load_sym   = syms[k];
            cyc();
            etape[k] = syms[k];
        end
        idle_in();
        expect_st("load3", 2'd0, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b1;
        cyc();
        idle_in();
        expect_st("start", 2'd1, 4'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);

        // Single step right
        bus.step_valid = 1'b1; bus.write_sym = 3'b111; bus.direction = 1'b1;
        cyc();
        idle_in();
        etape[0] = 3'b111;
        expect_st("step1", 2'd1, 4'd1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back steps: right, right, left
        bus.step_valid = 1'b1; bus.write_sym = 3'b011; bus.direction = 1'b1;
        cyc();
        etape[1] = 3'b011;
        expect_st("b2b0", 2'd1, 4'd2, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.write_sym = 3'b101; bus.direction = 1'b1;
        cyc();
        etape[2] = 3'b101;
        expect_st("b2b1", 2'd1, 4'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.write_sym = 3'b110; bus.direction = 1'b0;
        cyc();
        idle_in();
        etape[3] = 3'b110;
        expect_st("b2b2", 2'd1, 4'd2, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();

        // Asynchronous reset in the middle of RUN
        bus.step_valid = 1'b1; bus.write_sym = 3'b111; bus.direction = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < TL; i++) etape[i] = 3'b000;
        expect_st("rst_async", 2'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle_in();
        rst_n = 1'b1;
        cyc();

        // Left-edge step from head 0
        bus.start = 1'b1;
        cyc();
        idle_in();
        expect_st("start2", 2'd1, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.step_valid = 1'b1; bus.write_sym = 3'b101; bus.direction = 1'b0;
        cyc();
        idle_in();
        etape[0] = 3'b101;
`ifdef TAPE_UNIT_WRAP_EN
        expect_st("left_edge", 2'd1, 4'd15, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        expect_st("left_edge", 2'd2, 4'd0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        bus.step_valid = 1'b1; bus.write_sym = 3'b010; bus.direction = 1'b1;
        cyc();
        idle_in();
`ifdef TAPE_UNIT_WRAP_EN
        etape[15] = 3'b010;
        expect_st("after_edge", 2'd1, 4'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        expect_st("after_edge", 2'd2, 4'd0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        bus.clr = 1'b1;
        cyc();
        idle_in();
        expect_st("clr", 2'd0, 4'd0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);

        // TAPE_LEN+1 loads: last one overflows without writing
        for (int k = 0; k <= TL; k++) begin
            s = (k < TL) ? 3'((k % 7) + 1) : 3'b111;
            bus.load_valid = 1'b1;
            bus.load_sym   = s;
            cyc();
            if (k < TL) etape[k] = s;
            if (k == TL - 1)
                expect_st("load16", 2'd0, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k == TL)
                expect_st("load17_ovf", 2'd0, 4'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle_in();

        // clr wins over start
        bus.clr = 1'b1; bus.start = 1'b1;
        cyc();
        idle_in();
        expect_st("clr_start", 2'd0, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);

        // Load and start together: load lands first
        bus.load_valid = 1'b1; bus.load_sym = 3'b011; bus.start = 1'b1;
        cyc();
        idle_in();
        etape[0] = 3'b011;
        expect_st("load_start", 2'd1, 4'd0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);

        // Walk to the right edge, then step past it
        bus.step_valid = 1'b1; bus.write_sym = 3'b110; bus.direction = 1'b1;
        for (int k = 0; k < TL - 1; k++) begin
            cyc();
            etape[k] = 3'b110;
        end
        expect_st("walk15", 2'd1, 4'd15, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        idle_in();
        etape[TL-1] = 3'b110;
`ifdef TAPE_UNIT_WRAP_EN
        expect_st("right_edge", 2'd1, 4'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        expect_st("right_edge", 2'd2, 4'd15, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

        // start/load must be ignored outside IDLE
        bus.start = 1'b1; bus.load_valid = 1'b1; bus.load_sym = 3'b001;
        cyc();
        idle_in();
`ifdef TAPE_UNIT_WRAP_EN
        expect_st("ignore_start", 2'd1, 4'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        expect_st("ignore_start", 2'd2, 4'd15, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        cyc();

        // Drain the scoreboard within a bounded number of cycles
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tape_unit
`default_nettype wire
